// File: rtl/tx_if_pkg.sv
// tx_if_pkg: shared header encodings, idle control word and small helpers for the TX interface stage.
package tx_if_pkg;
    localparam logic [1:0]  HDR_DATA       = 2'b01;
    localparam logic [1:0]  HDR_CTRL       = 2'b10;
    localparam logic [63:0] IDLE_CTRL_WORD = 64'h1E00_0000_0000_0000;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/tx_sync_fifo.sv
// tx_sync_fifo: synchronous FIFO with wrapping pointers and a separate fill counter.
module tx_sync_fifo #(
    parameter int W     = 66,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = level == LW'(DEPTH);
    assign empty = level == '0;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end
endmodule

// File: rtl/tx_interface_fifo.sv
// tx_interface_fifo: buffers user header+data words and feeds the gearbox one word per cycle,
// substituting an idle control word when disabled or starved.
module tx_interface_fifo import tx_if_pkg::*; #(
    parameter int                DATA_W      = 64,
    parameter int                HDR_W       = 2,
    parameter int                DEPTH       = 8,
    parameter logic [DATA_W-1:0] IDLE_WORD   = IDLE_CTRL_WORD,
    parameter logic [HDR_W-1:0]  IDLE_HEADER = HDR_CTRL
) (
    input  logic                     USER_CLK,
    input  logic                     SYSTEM_RESET_N,
    input  logic [DATA_W-1:0]        DATA_IN,
    input  logic [HDR_W-1:0]         HEADER_IN,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic                     TX_ENABLE,
    input  logic                     TX_PAUSE,
    output logic [DATA_W-1:0]        DATA_OUT,
    output logic [HDR_W-1:0]         HEADER_OUT,
    output logic                     DATA_VALID_OUT,
    output logic [$clog2(DEPTH):0]   FILL_LEVEL,
    output logic [15:0]              UNDERRUN_COUNT
);
    logic                     full, empty, push, pop;
    logic [HDR_W+DATA_W-1:0]  head;

    assign IN_READY = !full;
    assign push     = IN_VALID && IN_READY;
    assign pop      = !TX_PAUSE && TX_ENABLE && !empty;

    tx_sync_fifo #(.W(HDR_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (USER_CLK),
        .rst_n (SYSTEM_RESET_N),
        .push  (push),
        .pop   (pop),
        .wdata ({HEADER_IN, DATA_IN}),
        .rdata (head),
        .level (FILL_LEVEL),
        .full  (full),
        .empty (empty)
    );

    // Pause freezes the whole output stage, including the underrun counter.
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            DATA_OUT       <= IDLE_WORD;
            HEADER_OUT     <= IDLE_HEADER;
            DATA_VALID_OUT <= 1'b0;
            UNDERRUN_COUNT <= '0;
        end else if (!TX_PAUSE) begin
            {HEADER_OUT, DATA_OUT} <= pop ? head : {IDLE_HEADER, IDLE_WORD};
            DATA_VALID_OUT         <= pop;
            if (TX_ENABLE && empty) UNDERRUN_COUNT <= sat_inc16(UNDERRUN_COUNT);
        end
    end
endmodule
